// File: rtl/golomb_search_ctrl.sv
// Sequencing controller for a Golomb ruler search: steps the mark counters one
// level at a time, records each accepted leaf position and tightens the bound.
module golomb_search_ctrl #(
  parameter int                 NUMPOSITIONS = 5,
  parameter int                 LEVEL_W      = 4,
  parameter int                 VALUE_W      = 8,
  parameter logic [VALUE_W-1:0] INIT_LIMIT   = 8'd17
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [LEVEL_W-1:0] next_enabled,
  input  logic               leaf_success,
  input  logic [VALUE_W-1:0] leaf_val,
  input  logic               all_ready,
  output logic               ctr_reset,
  output logic               globalready,
  output logic [LEVEL_W-1:0] enabled,
  output logic [VALUE_W-1:0] limit,
  output logic [VALUE_W-1:0] best_len,
  output logic               found,
  output logic [15:0]        ruler_cnt,
  output logic [31:0]        step_cnt,
  output logic               busy,
  output logic               done,
  output logic [2:0]         fsm_state
);

  // Handshake: globalready is a one-cycle strobe raised only when all_ready was
  // seen high in ISSUE; counter results are sampled on the edge that ends it.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    ISSUE   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [LEVEL_W-1:0] LEAF      = LEVEL_W'(NUMPOSITIONS);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);

  state_t state;
  logic   accept;
  logic   stop;

  assign fsm_state = state;
  assign accept    = (enabled == LEAF) && leaf_success && (leaf_val <= limit);
  assign stop      = (next_enabled == '0) || (next_enabled > LEAF);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ctr_reset   <= 1'b0;
      globalready <= 1'b0;
      enabled     <= '0;
      limit       <= INIT_LIMIT;
      best_len    <= '0;
      found       <= 1'b0;
      ruler_cnt   <= '0;
      step_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      found <= 1'b0;
      if (abort && state != IDLE) begin
        state       <= IDLE;
        ctr_reset   <= 1'b0;
        globalready <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= INIT;
              ctr_reset <= 1'b1;
              busy      <= 1'b1;
              step_cnt  <= '0;
              ruler_cnt <= '0;
              best_len  <= '0;
              limit     <= INIT_LIMIT;
              enabled   <= LEVEL_ONE;
            end
          end
          INIT: begin
            ctr_reset <= 1'b0;
            state     <= ISSUE;
          end
          ISSUE: begin
            if (all_ready) begin
              globalready <= 1'b1;
              if (step_cnt != '1) step_cnt <= step_cnt + 32'd1;
              state <= CAPTURE;
            end
          end
          CAPTURE: begin
            globalready <= 1'b0;
            // A ruler found together with next_enabled==0 is still recorded.
            if (accept) begin
              best_len <= leaf_val;
              limit    <= (leaf_val == '0) ? '0 : leaf_val - VALUE_W'(1);
              found    <= 1'b1;
              if (ruler_cnt != '1) ruler_cnt <= ruler_cnt + 16'd1;
            end
            if (stop) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              enabled <= next_enabled;
              state   <= ISSUE;
            end
          end
          DONE: begin
            if (!start) begin
              state <= IDLE;
              done  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_golomb_search_ctrl.sv
// Directed bench for golomb_search_ctrl: reset, stepping cadence, ruler capture,
// stall on all_ready, protocol error, abort and asynchronous reset.
module tb_golomb_search_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [3:0]  next_enabled;
  logic        leaf_success;
  logic [7:0]  leaf_val;
  logic        all_ready;
  logic        ctr_reset;
  logic        globalready;
  logic [3:0]  enabled;
  logic [7:0]  limit;
  logic [7:0]  best_len;
  logic        found;
  logic [15:0] ruler_cnt;
  logic [31:0] step_cnt;
  logic        busy;
  logic        done;
  logic [2:0]  fsm_state;

  int passed = 0;
  int total  = 0;

  golomb_search_ctrl dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .next_enabled(next_enabled), .leaf_success(leaf_success), .leaf_val(leaf_val),
    .all_ready(all_ready), .ctr_reset(ctr_reset), .globalready(globalready),
    .enabled(enabled), .limit(limit), .best_len(best_len), .found(found),
    .ruler_cnt(ruler_cnt), .step_cnt(step_cnt), .busy(busy), .done(done),
    .fsm_state(fsm_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; next_enabled = 4'd1;
    leaf_success = 1'b0; leaf_val = 8'd0; all_ready = 1'b1;
    tick(); tick();
    check("rst_state", 32'(fsm_state), 32'd0);
    check("rst_enabled", 32'(enabled), 32'd0);
    check("rst_limit", 32'(limit), 32'd17);
    check("rst_gr", 32'(globalready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_step", step_cnt, 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_hold", 32'(fsm_state), 32'd0);

    // Normal search: stepping cadence, then a stall on all_ready.
    start = 1'b1;
    tick();
    check("init_ctr_reset", 32'(ctr_reset), 32'd1);
    check("init_busy", 32'(busy), 32'd1);
    check("init_enabled", 32'(enabled), 32'd1);
    check("init_gr", 32'(globalready), 32'd0);
    start = 1'b0;
    tick();
    check("issue_ctr_reset", 32'(ctr_reset), 32'd0);
    check("issue_gr", 32'(globalready), 32'd0);
    tick();
    check("cap1_gr", 32'(globalready), 32'd1);
    check("cap1_step", step_cnt, 32'd1);
    tick();
    check("iss2_gr", 32'(globalready), 32'd0);
    check("iss2_enabled", 32'(enabled), 32'd1);
    tick();
    check("cap2_gr", 32'(globalready), 32'd1);
    check("cap2_step", step_cnt, 32'd2);
    next_enabled = 4'd5;
    tick();
    check("iss3_enabled", 32'(enabled), 32'd5);
    all_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_gr", 32'(globalready), 32'd0);
    end
    check("stall_step", step_cnt, 32'd2);
    all_ready = 1'b1;
    tick();
    check("unstall_gr", 32'(globalready), 32'd1);
    check("unstall_step", step_cnt, 32'd3);

    // Leaf success at the bound.
    leaf_success = 1'b1; leaf_val = 8'd17;
    tick();
    check("rul1_found", 32'(found), 32'd1);
    check("rul1_best", 32'(best_len), 32'd17);
    check("rul1_limit", 32'(limit), 32'd16);
    check("rul1_cnt", 32'(ruler_cnt), 32'd1);
    tick();
    check("rul1_found_pulse", 32'(found), 32'd0);
    check("cap4_step", step_cnt, 32'd4);
    // Same length again now exceeds the tightened bound.
    tick();
    check("over_limit_found", 32'(found), 32'd0);
    check("over_limit_cnt", 32'(ruler_cnt), 32'd1);
    check("over_limit_limit", 32'(limit), 32'd16);
    tick();
    // Success and termination in the same capture.
    leaf_val = 8'd12; next_enabled = 4'd0;
    tick();
    check("rul2_found", 32'(found), 32'd1);
    check("rul2_best", 32'(best_len), 32'd12);
    check("rul2_limit", 32'(limit), 32'd11);
    check("rul2_cnt", 32'(ruler_cnt), 32'd2);
    check("done_flag", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_enabled", 32'(enabled), 32'd5);
    leaf_success = 1'b0;
    start = 1'b1;
    tick();
    check("done_gr", 32'(globalready), 32'd0);
    check("done_step", step_cnt, 32'd5);
    check("done_held", 32'(fsm_state), 32'd4);
    start = 1'b0;
    tick();
    check("back_idle", 32'(fsm_state), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_best", 32'(best_len), 32'd12);

    // Protocol error: next_enabled beyond the leaf.
    next_enabled = 4'd7;
    start = 1'b1;
    tick();
    check("restart_best", 32'(best_len), 32'd0);
    check("restart_cnt", 32'(ruler_cnt), 32'd0);
    check("restart_limit", 32'(limit), 32'd17);
    check("restart_step", step_cnt, 32'd0);
    start = 1'b0;
    tick(); tick(); tick();
    check("perr_done", 32'(done), 32'd1);
    check("perr_enabled", 32'(enabled), 32'd1);
    tick();
    check("perr_idle", 32'(fsm_state), 32'd0);

    // Abort during a successful capture.
    next_enabled = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check("abort_pre_state", 32'(fsm_state), 32'd3);
    leaf_success = 1'b1; leaf_val = 8'd10; abort = 1'b1;
    tick();
    check("abort_state", 32'(fsm_state), 32'd0);
    check("abort_found", 32'(found), 32'd0);
    check("abort_cnt", 32'(ruler_cnt), 32'd0);
    check("abort_gr", 32'(globalready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    abort = 1'b0; leaf_success = 1'b0;
    tick();
    check("abort_found_after", 32'(found), 32'd0);

    // Asynchronous reset while waiting in ISSUE.
    next_enabled = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("pre_rst_step", step_cnt, 32'd1);
    tick();
    all_ready = 1'b0;
    tick();
    check("pre_rst_state", 32'(fsm_state), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check("arst_state", 32'(fsm_state), 32'd0);
    check("arst_limit", 32'(limit), 32'd17);
    check("arst_enabled", 32'(enabled), 32'd0);
    check("arst_step", step_cnt, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    all_ready = 1'b1;
    tick();
    check("arst_gr", 32'(globalready), 32'd0);
    reset_n = 1'b1;
    tick();
    check("post_rst_state", 32'(fsm_state), 32'd0);
    check("post_rst_gr", 32'(globalready), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
